// File: rtl/cp0_exc_unit_if.sv
// M-stage pipeline <-> CP0 bus: mfc0/mtc0 access, exception inputs, redirect outputs.
interface cp0_exc_unit_if;
    logic [4:0]  a_sel;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        valid_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic        take_exc;
    logic [31:0] epc_out;
    logic        exl_out;

    modport master (
        output a_sel, we, wd, pc_m, bd_m, valid_m, exc_code_m, eret_m,
        input  rd, take_exc, epc_out, exl_out
    );

    modport slave (
        input  a_sel, we, wd, pc_m, bd_m, valid_m, exc_code_m, eret_m,
        output rd, take_exc, epc_out, exl_out
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 register file and M-stage exception/interrupt controller.
// Optional Count/Compare timer enabled by defining CP0_COUNT_EN.
module cp0_exc_unit #(
    parameter int unsigned NUM_HWINT     = 6,
    parameter logic [5:0]  INT_EDGE_MASK = 6'b000000,
    parameter logic [31:0] PRID          = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_exc_unit_if.slave        bus,
    input  logic [NUM_HWINT-1:0] hw_int
);
    localparam int unsigned IP_W = 6;
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [IP_W-1:0] LINE_MASK = IP_W'((7'd1 << NUM_HWINT) - 7'd1);
    localparam logic [IP_W-1:0] EDGE_BITS = INT_EDGE_MASK & LINE_MASK;

    logic [IP_W-1:0] hw_prev, ip_hw, ip_hw_d, hw_ext, rise, keep, ip;
    logic [IP_W-1:0] sr_im;
    logic            sr_exl, sr_ie;
    logic            cause_bd;
    logic [4:0]      cause_exc;
    logic [31:0]     epc, epc_capture;
    logic            irq, exc, tx, wr, ti;

    // Exception/interrupt decision and pending-bit next state
    always_comb begin
        hw_ext      = IP_W'(hw_int);
        rise        = hw_ext & ~hw_prev;
        ip          = ip_hw | {ti, 5'b00000};
        irq         = (|(ip & sr_im)) & sr_ie & ~sr_exl & bus.valid_m;
        exc         = (bus.exc_code_m != 5'd0) & bus.valid_m;
        tx          = reset & (irq | exc);
        wr          = bus.we & ~tx;
        keep        = (wr && bus.a_sel == REG_CAUSE) ? bus.wd[15:10] : '1;
        // a new edge beats a software clear in the same cycle
        ip_hw_d     = LINE_MASK & ((~EDGE_BITS & hw_ext) |
                                   (EDGE_BITS & ((ip_hw & keep) | rise)));
        epc_capture = (bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m) & ~32'd3;
    end

    assign bus.take_exc = tx;
    assign bus.epc_out  = epc;
    assign bus.exl_out  = sr_exl;

    // SR / Cause / EPC state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hw_prev   <= '0;
            ip_hw     <= '0;
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            hw_prev <= hw_ext;
            ip_hw   <= ip_hw_d;
            if (tx) begin
                cause_exc <= irq ? 5'd0 : bus.exc_code_m;
                if (!sr_exl) begin
                    epc      <= epc_capture;
                    cause_bd <= bus.bd_m;
                end
                sr_exl <= 1'b1;
            end else begin
                if (bus.eret_m) begin
                    sr_exl <= 1'b0;
                end else if (wr && bus.a_sel == REG_SR) begin
                    sr_exl <= bus.wd[1];
                end
                if (wr && bus.a_sel == REG_SR) begin
                    sr_im <= bus.wd[15:10];
                    sr_ie <= bus.wd[0];
                end
                if (wr && bus.a_sel == REG_EPC) begin
                    epc <= bus.wd & ~32'd3;
                end
            end
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count, compare;

    if (NUM_HWINT > 5) begin : g_hwint_check
        $error("NUM_HWINT must be at most 5 when the timer is compiled in");
    end

    // Free-running timer; a Compare write clears TI even on a match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            count <= (wr && bus.a_sel == REG_COUNT) ? bus.wd : count + 32'd1;
            if (wr && bus.a_sel == REG_COMPARE) begin
                compare <= bus.wd;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign ti = 1'b0;
`endif

    // mfc0 read mux
    always_comb begin
        bus.rd = 32'd0;
        case (bus.a_sel)
            REG_SR:    bus.rd = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
            REG_CAUSE: bus.rd = {cause_bd, ti, 14'h0000, ip, 3'b000, cause_exc, 2'b00};
            REG_EPC:   bus.rd = epc;
            REG_PRID:  bus.rd = PRID;
`ifdef CP0_COUNT_EN
            REG_COUNT:   bus.rd = count;
            REG_COMPARE: bus.rd = compare;
`endif
            default:   bus.rd = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit (line 1 configured edge-triggered).
module tb_cp0_exc_unit;
`ifdef CP0_COUNT_EN
    localparam int unsigned NHW = 5;
`else
    localparam int unsigned NHW = 6;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [NHW-1:0] hw_int;
    int             n_checks = 0;
    int             n_fail   = 0;

    always #5 clk = ~clk;

    cp0_exc_unit_if bus();

    cp0_exc_unit #(
        .NUM_HWINT    (NHW),
        .INT_EDGE_MASK(6'b000010),
        .PRID         (32'h0000_0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .hw_int(hw_int)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.a_sel = 5'd0; bus.we = 1'b0; bus.wd = 32'd0; bus.pc_m = 32'd0;
        bus.bd_m = 1'b0; bus.valid_m = 1'b0; bus.exc_code_m = 5'd0; bus.eret_m = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.a_sel = r; bus.wd = d; bus.we = 1'b1; bus.valid_m = 1'b1;
        tick();
        bus.we = 1'b0; bus.valid_m = 1'b0;
    endtask

    task automatic do_eret;
        bus.eret_m = 1'b1; bus.valid_m = 1'b1;
        tick();
        bus.eret_m = 1'b0; bus.valid_m = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; hw_int = '0; idle();
        #2 reset = 1'b0;
        #2;
        n_checks++; if (bus.take_exc !== 1'b0) begin n_fail++; $display("FAIL reset_take: got %b want 0", bus.take_exc); end
        n_checks++; if (bus.exl_out !== 1'b0) begin n_fail++; $display("FAIL reset_exl: got %b want 0", bus.exl_out); end
        n_checks++; if (bus.epc_out !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", bus.epc_out); end
        bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", bus.rd); end
        bus.a_sel = 5'd15; #1;
        n_checks++; if (bus.rd !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_prid: got %h want 00000001", bus.rd); end
        @(negedge clk) reset = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_level_int;
        mtc0(5'd12, 32'h0000_0401);
        bus.pc_m = 32'h3008; bus.valid_m = 1'b1; hw_int = NHW'(1);
        #1;
        n_checks++; if (bus.take_exc !== 1'b0) begin n_fail++; $display("FAIL level_pre: got %b want 0", bus.take_exc); end
        tick();
        hw_int = '0;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL level_take: got %b want 1", bus.take_exc); end
        tick();
        n_checks++; if (bus.epc_out !== 32'h3008) begin n_fail++; $display("FAIL level_epc: got %h want 00003008", bus.epc_out); end
        n_checks++; if (bus.exl_out !== 1'b1) begin n_fail++; $display("FAIL level_exl: got %b want 1", bus.exl_out); end
        idle(); bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL level_cause: got %h want 0", bus.rd); end
        do_eret();
        n_checks++; if (bus.exl_out !== 1'b0) begin n_fail++; $display("FAIL level_eret: got %b want 0", bus.exl_out); end
    endtask

    task automatic test_delay_slot;
        bus.exc_code_m = 5'd12; bus.bd_m = 1'b1; bus.pc_m = 32'h3010; bus.valid_m = 1'b1;
        #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL ds_take: got %b want 1", bus.take_exc); end
        tick();
        idle(); bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'h8000_0030) begin n_fail++; $display("FAIL ds_cause: got %h want 80000030", bus.rd); end
        n_checks++; if (bus.epc_out !== 32'h300C) begin n_fail++; $display("FAIL ds_epc: got %h want 0000300c", bus.epc_out); end
        do_eret();
        hw_int = NHW'(1);
        tick();
        bus.exc_code_m = 5'd12; bus.bd_m = 1'b1; bus.pc_m = 32'h3010; bus.valid_m = 1'b1;
        #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL prio_take: got %b want 1", bus.take_exc); end
        tick();
        hw_int = '0;
        idle(); bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'h8000_0400) begin n_fail++; $display("FAIL prio_cause: got %h want 80000400", bus.rd); end
        n_checks++; if (bus.epc_out !== 32'h300C) begin n_fail++; $display("FAIL prio_epc: got %h want 0000300c", bus.epc_out); end
        do_eret();
    endtask

    task automatic test_edge_line;
        mtc0(5'd12, 32'h0000_0800);
        hw_int = NHW'(2);
        tick();
        hw_int = '0;
        tick(); tick();
        bus.valid_m = 1'b1; bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'h8000_0800) begin n_fail++; $display("FAIL edge_held: got %h want 80000800", bus.rd); end
        n_checks++; if (bus.take_exc !== 1'b0) begin n_fail++; $display("FAIL edge_ie0: got %b want 0", bus.take_exc); end
        mtc0(5'd12, 32'h0000_0801);
        bus.valid_m = 1'b1; bus.pc_m = 32'h4000; #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL edge_take: got %b want 1", bus.take_exc); end
        tick();
        idle(); bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'h0000_0800) begin n_fail++; $display("FAIL edge_cause: got %h want 00000800", bus.rd); end
        n_checks++; if (bus.epc_out !== 32'h4000) begin n_fail++; $display("FAIL edge_epc: got %h want 00004000", bus.epc_out); end
        mtc0(5'd13, 32'd0); #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL edge_clear: got %h want 0", bus.rd); end
        hw_int = NHW'(2);
        mtc0(5'd13, 32'd0); #1;
        n_checks++; if (bus.rd !== 32'h0000_0800) begin n_fail++; $display("FAIL edge_wins: got %h want 00000800", bus.rd); end
        mtc0(5'd13, 32'd0); #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL edge_clear2: got %h want 0", bus.rd); end
        hw_int = '0;
        mtc0(5'd13, 32'hFFFF_FFFF); #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL cause_ro: got %h want 0", bus.rd); end
        do_eret();
    endtask

    task automatic test_nested_eret;
        bus.exc_code_m = 5'd8; bus.pc_m = 32'h5000; bus.valid_m = 1'b1;
        tick();
        bus.exc_code_m = 5'd10; bus.pc_m = 32'h6000; bus.bd_m = 1'b1;
        bus.we = 1'b1; bus.a_sel = 5'd14; bus.wd = 32'h1234_5678;
        #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL nest_take: got %b want 1", bus.take_exc); end
        tick();
        idle();
        n_checks++; if (bus.epc_out !== 32'h5000) begin n_fail++; $display("FAIL nest_epc: got %h want 00005000", bus.epc_out); end
        bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'h0000_0028) begin n_fail++; $display("FAIL nest_cause: got %h want 00000028", bus.rd); end
        bus.eret_m = 1'b1; bus.valid_m = 1'b1; #1;
        n_checks++; if (bus.take_exc !== 1'b0) begin n_fail++; $display("FAIL eret_notake: got %b want 0", bus.take_exc); end
        tick();
        idle();
        n_checks++; if (bus.exl_out !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b want 0", bus.exl_out); end
        do_eret();
        n_checks++; if (bus.exl_out !== 1'b0 || bus.epc_out !== 32'h5000) begin n_fail++; $display("FAIL eret_idle: got exl %b epc %h want 0 00005000", bus.exl_out, bus.epc_out); end
        mtc0(5'd14, 32'h1234_5677);
        n_checks++; if (bus.epc_out !== 32'h1234_5674) begin n_fail++; $display("FAIL epc_write: got %h want 12345674", bus.epc_out); end
        mtc0(5'd12, 32'hFFFF_FFFF); bus.a_sel = 5'd12; #1;
        n_checks++; if (bus.rd !== 32'h0000_FC03) begin n_fail++; $display("FAIL sr_write: got %h want 0000fc03", bus.rd); end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_bubble_reset;
        mtc0(5'd12, 32'h0000_0401);
        hw_int = NHW'(1); bus.pc_m = 32'h7000;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.take_exc !== 1'b0) begin n_fail++; $display("FAIL bubble_wait%0d: got %b want 0", i, bus.take_exc); end
            tick();
        end
        bus.valid_m = 1'b1; bus.eret_m = 1'b1; #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL bubble_take: got %b want 1", bus.take_exc); end
        tick();
        idle(); hw_int = '0;
        n_checks++; if (bus.exl_out !== 1'b1 || bus.epc_out !== 32'h7000) begin n_fail++; $display("FAIL eret_irq: got exl %b epc %h want 1 00007000", bus.exl_out, bus.epc_out); end
        bus.valid_m = 1'b1; bus.exc_code_m = 5'd4; bus.a_sel = 5'd14; #1;
        n_checks++; if (bus.take_exc !== 1'b1) begin n_fail++; $display("FAIL prereset_take: got %b want 1", bus.take_exc); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.take_exc !== 1'b0 || bus.exl_out !== 1'b0) begin n_fail++; $display("FAIL async_reset: got take %b exl %b want 0 0", bus.take_exc, bus.exl_out); end
        n_checks++; if (bus.epc_out !== 32'd0 || bus.rd !== 32'd0) begin n_fail++; $display("FAIL async_epc: got epc %h rd %h want 0 0", bus.epc_out, bus.rd); end
        idle();
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

`ifdef CP0_COUNT_EN
    task automatic test_timer;
        int cyc;
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        bus.valid_m = 1'b1; bus.pc_m = 32'h8000; bus.a_sel = 5'd13;
        cyc = 0;
        #0;
        while (bus.take_exc !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL timer_latency: got %0d want 20", cyc); end
        n_checks++; if (bus.rd !== 32'h4000_8000) begin n_fail++; $display("FAIL timer_cause: got %h want 40008000", bus.rd); end
        tick();
        idle();
        mtc0(5'd11, 32'd100); bus.a_sel = 5'd13; #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL timer_ticlr: got %h want 0", bus.rd); end
        bus.a_sel = 5'd11; #1;
        n_checks++; if (bus.rd !== 32'd100) begin n_fail++; $display("FAIL timer_compare: got %h want 100", bus.rd); end
        do_eret();
    endtask
`else
    task automatic test_no_timer;
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd7);
        bus.a_sel = 5'd9; #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL no_count: got %h want 0", bus.rd); end
        bus.a_sel = 5'd11; #1;
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL no_compare: got %h want 0", bus.rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_level_int();
        test_delay_slot();
        test_edge_line();
        test_nested_eret();
        test_bubble_reset();
`ifdef CP0_COUNT_EN
        test_timer();
`else
        test_no_timer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
